// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: default widths, state and writeback-select encodings.
package wb_regfile_pkg;

  localparam int unsigned DEF_DATAPATH_WIDTH     = 64;
  localparam int unsigned DEF_REGFILE_ADDR_WIDTH = 5;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic WB_SEL_ACC = 1'b0;

endpackage

// File: rtl/wb_regfile_rf_clear_seq.sv
// Post-reset clear sequencer: walks every register file entry once, then declares the file ready.
module wb_regfile_rf_clear_seq
  import wb_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  o_clr_we_c,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic                  o_rf_ready_c
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

  rf_state_e             r_state;
  rf_state_e             w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;

  // State register and sweep counter; reset restarts the sweep even mid-way.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RF_ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == RF_ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Leave CLEAR right after the last entry is written, so the counter never wraps in use.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RF_ST_CLEAR: if (r_clr_cnt == LAST_ENTRY) w_next_state = RF_ST_READY;
      RF_ST_READY: w_next_state = RF_ST_READY;
      default:     w_next_state = RF_ST_CLEAR;
    endcase
  end

  always_comb begin
    o_clr_we_c   = 1'b0;
    o_rf_ready_c = 1'b0;
    case (r_state)
      RF_ST_CLEAR: o_clr_we_c   = 1'b1;
      RF_ST_READY: o_rf_ready_c = 1'b1;
      default:     o_clr_we_c   = 1'b0;
    endcase
  end

  assign o_clr_addr = r_clr_cnt;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: MEM/WB result mux, 2R/1W array, post-reset clear sweep.
// Optional `WB_BYPASS_EN forwards a same-cycle writeback onto matching read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH     = DEF_DATAPATH_WIDTH,
  parameter int unsigned REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATAPATH_WIDTH-1:0]     mem_data_in,
  input  logic [DATAPATH_WIDTH-1:0]     accum_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
  input  logic                          WR_en_in,
  input  logic                          wb_sel_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATAPATH_WIDTH-1:0]     rs1_data,
  output logic [DATAPATH_WIDTH-1:0]     rs2_data,
  output logic                          rf_ready
);

  localparam int unsigned DEPTH = 2 ** REGFILE_ADDR_WIDTH;

  logic [DATAPATH_WIDTH-1:0]     r_regs [DEPTH];
  logic                          w_clr_we;
  logic [REGFILE_ADDR_WIDTH-1:0] w_clr_addr;
  logic                          w_rf_ready;
  logic                          w_user_we;
  logic [DATAPATH_WIDTH-1:0]     w_wb_data;

  wb_regfile_rf_clear_seq #(
    .ADDR_WIDTH (REGFILE_ADDR_WIDTH)
  ) u_clear_seq (
    .clk          (clk),
    .reset        (reset),
    .o_clr_we_c   (w_clr_we),
    .o_clr_addr   (w_clr_addr),
    .o_rf_ready_c (w_rf_ready)
  );

  assign w_wb_data = (wb_sel_in == WB_SEL_MEM) ? mem_data_in : accum_in;
  assign w_user_we = w_rf_ready && WR_en_in && (WR_addr_in != '0) && !reset;
  assign rf_ready  = w_rf_ready;

  // No array reset: the sweep owns the write port until READY, keeping the array RAM-mappable.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_regs[WR_addr_in] <= w_wb_data;
    end
  end

`ifdef WB_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;
  assign w_fwd1 = w_rf_ready && WR_en_in && (WR_addr_in == rs1_addr);
  assign w_fwd2 = w_rf_ready && WR_en_in && (WR_addr_in == rs2_addr);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (w_rf_ready && (rs1_addr != '0)) rs1_data = w_fwd1 ? w_wb_data : r_regs[rs1_addr];
    if (w_rf_ready && (rs2_addr != '0)) rs2_data = w_fwd2 ? w_wb_data : r_regs[rs2_addr];
  end
`else
  // Without forwarding a same-cycle read sees the old value; the hazard unit stalls instead.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (w_rf_ready && (rs1_addr != '0)) rs1_data = r_regs[rs1_addr];
    if (w_rf_ready && (rs2_addr != '0)) rs2_data = r_regs[rs2_addr];
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations queued at drive time, checked at the following negedge.
module tb_wb_regfile;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] accum_in;
  logic [AW-1:0] WR_addr_in;
  logic          WR_en_in;
  logic          wb_sel_in;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          rf_ready;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .mem_data_in (mem_data_in),
    .accum_in    (accum_in),
    .WR_addr_in  (WR_addr_in),
    .WR_en_in    (WR_en_in),
    .wb_sel_in   (wb_sel_in),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rf_ready    (rf_ready)
  );

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int port, input logic [DW-1:0] val);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Sample at negedge, retire every queued expectation, then move to just after the next posedge.
  task automatic step();
    exp_t e;
    logic [DW-1:0] got;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       got = rs1_data;
        1:       got = rs2_data;
        default: got = DW'(rf_ready);
      endcase
      check_val(e.tag, got, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Count not-ready cycles (bounded); writes held during the sweep are dropped on ready.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (rf_ready) break;
      if (n == 5) check_val({tag, "_clear_rd"}, rs1_data, '0);
      n++;
      @(posedge clk);
      #1;
    end
    WR_en_in = 1'b0;
    check_val({tag, "_cycles"}, DW'(n), DW'(32));
    @(posedge clk);
    #1;
  endtask

  task automatic write_rf(input logic [AW-1:0] a, input logic sel, input logic [DW-1:0] m,
                          input logic [DW-1:0] acc);
    WR_en_in    = 1'b1;
    WR_addr_in  = a;
    wb_sel_in   = sel;
    mem_data_in = m;
    accum_in    = acc;
    step();
    if (a != '0) model[a] = sel ? m : acc;
    WR_en_in = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(DEPTH - 1 - i);
      push_exp($sformatf("%s_rs1_%0d", tag, i), 0, model[i]);
      push_exp($sformatf("%s_rs2_%0d", tag, DEPTH - 1 - i), 1, model[DEPTH - 1 - i]);
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    mem_data_in = '0;
    accum_in    = '0;
    WR_addr_in  = '0;
    WR_en_in    = 1'b0;
    wb_sel_in   = 1'b0;
    rs1_addr    = AW'(4);
    rs2_addr    = '0;
    clear_model();

    // Reset and sweep length
    pulse_reset();
    wait_ready("sweep1");
    push_exp("ready_hi", 2, DW'(1));
    step();
    read_all("init");

    // Mux select, both ports on the same register
    rs1_addr = AW'(5);
    rs2_addr = AW'(5);
    write_rf(AW'(5), 1'b1, 64'hDEAD_BEEF, 64'h1);
    push_exp("sel_mem_rs1", 0, 64'hDEAD_BEEF);
    push_exp("sel_mem_rs2", 1, 64'hDEAD_BEEF);
    step();
    write_rf(AW'(5), 1'b0, 64'hDEAD_BEEF, 64'h1);
    push_exp("sel_acc_rs1", 0, 64'h1);
    step();

    // Register 0 stays zero
    rs1_addr = '0;
    rs2_addr = '0;
    write_rf('0, 1'b1, 64'hFFFF, 64'hFFFF);
    push_exp("r0_rs1", 0, '0);
    push_exp("r0_rs2", 1, '0);
    step();

    // Same-cycle write/read hazard
    rs2_addr    = AW'(7);
    WR_en_in    = 1'b1;
    WR_addr_in  = AW'(7);
    wb_sel_in   = 1'b0;
    accum_in    = 64'hA5;
    mem_data_in = 64'h3C;
`ifdef WB_BYPASS_EN
    push_exp("hazard_same", 1, 64'hA5);
`else
    push_exp("hazard_same", 1, '0);
`endif
    step();
    model[7] = 64'hA5;
    WR_en_in = 1'b0;
    push_exp("hazard_next", 1, 64'hA5);
    step();

    // Random writes against the model
    for (int k = 0; k < 8; k++) begin
      write_rf(AW'($urandom_range(1, DEPTH - 1)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom});
    end
    read_all("rand");

    // Reset mid-sweep restarts the clear; writes during CLEAR are dropped
    rs1_addr = AW'(9);
    write_rf(AW'(9), 1'b1, 64'h55, 64'h0);
    push_exp("r9_pre", 0, 64'h55);
    step();
    pulse_reset();
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    pulse_reset();
    WR_en_in    = 1'b1;
    WR_addr_in  = AW'(3);
    wb_sel_in   = 1'b1;
    mem_data_in = 64'h77;
    wait_ready("sweep2");
    rs1_addr = AW'(9);
    rs2_addr = AW'(3);
    push_exp("r9_post", 0, '0);
    push_exp("r3_drop", 1, '0);
    step();
    read_all("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
